// File: rtl/dp_ctrl_if.sv
// dp_ctrl_if: signal bundle between the dp_ctrl sequencer and its environment
// (instruction memory, data memory and the datapath it steers).
//
// Handshakes: instr_req is held high with pc stable until the first cycle in
// which instr_valid is also high; that cycle completes the fetch and
// instr_data is captured. mem_req works the same way with mem_addr and
// mem_valid. A valid seen while the matching request is low is ignored.
interface dp_ctrl_if #(
    parameter int PC_W = 8
);
    // run control
    logic            run;
    // instruction fetch
    logic            instr_req;
    logic [PC_W-1:0] pc;
    logic            instr_valid;
    logic [7:0]      instr_data;
    // data memory read
    logic            mem_req;
    logic [3:0]      mem_addr;
    logic            mem_valid;
    // datapath strobes
    logic            in_load_accu;
    logic            in_arithMemory;
    logic            execute_en_in;
    logic            in_add;
    logic            in_addi;
    logic            in_sub;
    logic            in_subi;
    logic            in_and;
    logic            in_or;
    logic            in_xor;
    logic            in_not;
    logic            shiftl;
    logic            shiftr;
    logic [3:0]      in_imm;
    // status
    logic            halted;
    logic            trap;

    // controller side
    modport master (
        input  run, instr_valid, instr_data, mem_valid,
        output instr_req, pc, mem_req, mem_addr,
        output in_load_accu, in_arithMemory, execute_en_in,
        output in_add, in_addi, in_sub, in_subi, in_and, in_or, in_xor, in_not,
        output shiftl, shiftr, in_imm, halted, trap
    );

    // memories / datapath / run source side
    modport slave (
        output run, instr_valid, instr_data, mem_valid,
        input  instr_req, pc, mem_req, mem_addr,
        input  in_load_accu, in_arithMemory, execute_en_in,
        input  in_add, in_addi, in_sub, in_subi, in_and, in_or, in_xor, in_not,
        input  shiftl, shiftr, in_imm, halted, trap
    );
endinterface

// File: rtl/dp_ctrl.sv
// dp_ctrl: instruction sequencer for an accumulator datapath.
// Fetches 8-bit instructions ([7:4] opcode, [3:0] operand), optionally reads a
// data-memory operand, then pulses one execute strobe to the datapath.
// Optional feature: define DP_CTRL_ILLEGAL_TRAP_EN to send opcodes D-F to a
// sticky TRAP state; otherwise they decode as NOP and trap stays 0.
// restart is an asynchronous active-high reset; all outputs decode from the
// registered state, so asserting restart clears them without waiting for clka.
module dp_ctrl #(
    parameter int PC_W = 8
) (
    input  logic       clka,
    input  logic       restart,
    dp_ctrl_if.master  bus,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEMRD  = 3'd3,
        S_EXEC   = 3'd4,
        S_LOAD   = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_SUBI = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_LDA  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [3:0]      opcode;
    logic [3:0]      operand;
    state_t          after_instr;

    assign opcode    = ir_q[7:4];
    assign operand   = ir_q[3:0];
    assign state_dbg = state_q;

    // Where a finished instruction goes: keep fetching only while run is high.
    assign after_instr = bus.run ? S_FETCH : S_IDLE;

    // State, program counter and instruction register.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, PC advance and IR capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // pc stays put until the fetch completes, then wraps naturally.
                if (bus.instr_valid) begin
                    ir_d    = bus.instr_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: state_d = S_MEMRD;
                    OP_ADDI, OP_SUBI, OP_SHL, OP_SHR:              state_d = S_EXEC;
                    OP_LDA:                                        state_d = S_LOAD;
                    OP_HALT:                                       state_d = S_HALT;
                    OP_NOP:                                        state_d = after_instr;
                    default: begin
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = after_instr;
`endif
                    end
                endcase
            end
            S_MEMRD: begin
                if (bus.mem_valid) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = after_instr;
            S_LOAD:  state_d = after_instr;
            // HALT and TRAP are only left through restart.
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Requests, datapath strobes and status decoded from the current state.
    always_comb begin
        bus.instr_req      = 1'b0;
        bus.pc             = pc_q;
        bus.mem_req        = 1'b0;
        bus.mem_addr       = 4'h0;
        bus.in_load_accu   = 1'b0;
        bus.in_arithMemory = 1'b0;
        bus.execute_en_in  = 1'b0;
        bus.in_add         = 1'b0;
        bus.in_addi        = 1'b0;
        bus.in_sub         = 1'b0;
        bus.in_subi        = 1'b0;
        bus.in_and         = 1'b0;
        bus.in_or          = 1'b0;
        bus.in_xor         = 1'b0;
        bus.in_not         = 1'b0;
        bus.shiftl         = 1'b0;
        bus.shiftr         = 1'b0;
        bus.in_imm         = 4'h0;
        bus.halted         = 1'b0;
        bus.trap           = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.instr_req = 1'b1;
            end
            S_DECODE: begin
                bus.in_imm = operand;
            end
            S_MEMRD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = operand;
                bus.in_imm   = operand;
                // The datapath latches reg_in in the same cycle the read returns.
                bus.in_arithMemory = bus.mem_valid;
            end
            S_EXEC: begin
                bus.execute_en_in = 1'b1;
                bus.in_imm        = operand;
                case (opcode)
                    OP_ADD:  bus.in_add  = 1'b1;
                    OP_ADDI: bus.in_addi = 1'b1;
                    OP_SUB:  bus.in_sub  = 1'b1;
                    OP_SUBI: bus.in_subi = 1'b1;
                    OP_AND:  bus.in_and  = 1'b1;
                    OP_OR:   bus.in_or   = 1'b1;
                    OP_XOR:  bus.in_xor  = 1'b1;
                    OP_NOT:  bus.in_not  = 1'b1;
                    OP_SHL:  bus.shiftl  = 1'b1;
                    OP_SHR:  bus.shiftr  = 1'b1;
                    default: ;
                endcase
            end
            S_LOAD: begin
                bus.in_load_accu = 1'b1;
                bus.in_imm       = operand;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            S_TRAP: begin
`ifdef DP_CTRL_ILLEGAL_TRAP_EN
                bus.trap = 1'b1;
`else
                bus.trap = 1'b0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: doc/dp_ctrl.md
DP_CTRL -- requirements
Module: dp_ctrl

Interface
REQ-001 SHALL have parameter: PC_W, default 8, program-counter and instruction-address width.
REQ-002 SHALL have port: clka  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: restart  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: run  input  1  enable fetch of next instruction.
REQ-005 SHALL have port: instr_req  output  1  instruction fetch request.
REQ-006 SHALL have port: pc  output  PC_W  instruction address, valid while instr_req.
REQ-007 SHALL have port: instr_valid  input  1  instr_data valid, completes fetch.
REQ-008 SHALL have port: instr_data  input  8  instruction; [7:4] opcode, [3:0] operand.
REQ-009 SHALL have port: mem_req  output  1  data-memory read request.
REQ-010 SHALL have port: mem_addr  output  4  data address (= operand), valid while mem_req.
REQ-011 SHALL have port: mem_valid  input  1  data-memory read data present on datapath reg_in.
REQ-012 SHALL have ports: in_load_accu, in_arithMemory, execute_en_in, in_add, in_addi, in_sub, in_subi, in_and, in_or, in_xor, in_not, shiftl, shiftr  output  1 each  datapath control strobes.
REQ-013 SHALL have port: in_imm  output  4  operand to datapath.
REQ-014 SHALL have ports: halted, trap  output  1 each  status.

Function
REQ-015 Opcodes SHALL be: 0 NOP, 1 ADD, 2 ADDI, 3 SUB, 4 SUBI, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 SHL, A SHR, B LDA, C HALT, D-F illegal.
REQ-016 Memory-operand ops SHALL be ADD, SUB, AND, OR, XOR, NOT; immediate ops SHALL be ADDI, SUBI, SHL, SHR.
REQ-017 FSM states SHALL be IDLE, FETCH, DECODE, MEMRD, EXEC, LOAD, HALT, TRAP.
REQ-018 IDLE: all strobes 0; run=1 -> FETCH next cycle.
REQ-019 FETCH: instr_req=1, pc stable; on instr_valid latch instr_data into IR, pc <= pc+1 (wraps modulo 2^PC_W), -> DECODE.
REQ-020 DECODE (1 cycle): memory op -> MEMRD; immediate op -> EXEC; LDA -> LOAD; NOP -> FETCH if run else IDLE; HALT -> HALT; illegal -> see REQ-032/033.
REQ-021 MEMRD: mem_req=1, mem_addr=IR[3:0]; in the cycle mem_valid=1, in_arithMemory=1 for exactly that cycle, then -> EXEC.
REQ-022 EXEC: execute_en_in=1 plus exactly one op strobe matching IR for exactly one cycle; -> FETCH if run else IDLE.
REQ-023 LOAD: in_load_accu=1 for exactly one cycle; -> FETCH if run else IDLE.
REQ-024 in_imm SHALL equal IR[3:0] from DECODE through EXEC/LOAD, else 0.
REQ-025 in_arithMemory and execute_en_in SHALL never be high in the same cycle; in_load_accu and execute_en_in likewise.
REQ-026 At most one op strobe high per cycle; op strobes high only with execute_en_in.
REQ-027 Latency: immediate op 3 cycles, memory op 4 cycles with zero-wait instr_valid/mem_valid; each wait cycle adds one.
REQ-028 run deasserted mid-instruction SHALL NOT abort it; the instruction completes, then -> IDLE.
REQ-029 HALT state: halted=1, no requests, held until restart.

Reset
REQ-030 restart=1 SHALL asynchronously force state IDLE, pc=0, IR=0, all outputs 0, including mid-fetch or mid-MEMRD; instr_valid/mem_valid arriving during reset are ignored.
REQ-031 Operation SHALL resume from IDLE on the first rising clka edge after restart falls.

Configuration
REQ-032 With DP_CTRL_ILLEGAL_TRAP_EN defined, illegal opcode SHALL go DECODE -> TRAP; trap=1 held, no requests, until restart.
REQ-033 Without DP_CTRL_ILLEGAL_TRAP_EN, illegal opcode SHALL behave as NOP and trap SHALL be tied 0.

Verification
REQ-034 restart pulse, run=1, instr 0x23 zero-wait -> instr_req at pc=0, then execute_en_in+in_addi with in_imm=3 for one cycle, 3 cycles after FETCH entry; pc=1.
REQ-035 instr 0x15, mem_valid after 2 wait cycles -> mem_addr=5 for 3 cycles, in_arithMemory 1 cycle with mem_valid, then execute_en_in+in_add next cycle, never overlapped.
REQ-036 PC_W=8, pc=0xFF, fetch -> pc wraps to 0x00.
REQ-037 instr 0xC0 -> halted=1, no further instr_req for 20 cycles; restart -> halted=0, pc=0.
REQ-038 instr 0xE0 -> with macro trap=1 and stall; without macro treated as NOP, next fetch at pc+1.
REQ-039 restart asserted during MEMRD with mem_req=1 -> mem_req and all strobes 0 immediately (before next clka edge).
